// File: rtl/multiplex_queue.sv
// Multiplexes ARGC argument streams into a tagged output queue.
// Channel choice comes from a select stream or round-robin arbitration.
module multiplex_queue #(
  parameter int ARGW  = 16,
  parameter int ARGC  = 2,
  parameter int DEPTH = 2,
  parameter int MODE  = 0,
  localparam int SELW = $clog2(ARGC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ARGC-1:0]      arg_stb,
  input  logic [ARGC*ARGW-1:0] arg_dat,
  output logic [ARGC-1:0]      arg_rdy,
  input  logic                 sel_stb,
  input  logic [SELW-1:0]      sel_dat,
  output logic                 sel_rdy,
  output logic                 out_stb,
  output logic [ARGW-1:0]      out_dat,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_rdy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [SELW:0]   NCH  = (SELW+1)'(ARGC);

  logic [ARGW-1:0] mem_dat [DEPTH] = '{default: '0};
  logic [SELW-1:0] mem_sel [DEPTH] = '{default: '0};
  logic [CW-1:0]   count  = '0;
  logic [AW-1:0]   wr_ptr = '0;
  logic [AW-1:0]   rd_ptr = '0;
  logic [SELW-1:0] ptr    = '0;

  logic [SELW-1:0] nxt_ptr;
  logic            space;
  logic            push;
  logic            pop;
  logic [ARGW-1:0] push_dat;
  logic [SELW-1:0] push_sel;
  logic            found;
  logic [SELW-1:0] gnt;
  logic [SELW-1:0] cand;
  int              idx;

  assign space   = (count != FULL) | out_rdy;
  assign pop     = (count != '0) & out_rdy;
  assign out_stb = (count != '0);
  assign out_dat = mem_dat[rd_ptr];
  assign out_sel = mem_sel[rd_ptr];

  always_comb begin
    arg_rdy  = '0;
    sel_rdy  = 1'b0;
    push     = 1'b0;
    push_dat = '0;
    push_sel = '0;
    nxt_ptr  = ptr;
    found    = 1'b0;
    gnt      = '0;
    cand     = '0;
    idx      = 0;
    if (MODE == 0) begin
      if (!rst && space && sel_stb) begin
        // out-of-range select is consumed without touching any channel
        if ({1'b0, sel_dat} >= NCH) begin
          sel_rdy = 1'b1;
        end else if (arg_stb[sel_dat]) begin
          sel_rdy          = 1'b1;
          arg_rdy[sel_dat] = 1'b1;
          push             = 1'b1;
          push_sel         = sel_dat;
          push_dat         = arg_dat[ARGW*int'(sel_dat) +: ARGW];
        end
      end
    end else begin
      for (int k = 0; k < ARGC; k++) begin
        idx = int'(ptr) + k;
        if (idx >= ARGC) idx = idx - ARGC;
        cand = SELW'(idx);
        if (!found && arg_stb[cand]) begin
          found = 1'b1;
          gnt   = cand;
        end
      end
      if (!rst && space && found) begin
        arg_rdy[gnt] = 1'b1;
        push         = 1'b1;
        push_sel     = gnt;
        push_dat     = arg_dat[ARGW*int'(gnt) +: ARGW];
        nxt_ptr      = ({1'b0, gnt} == NCH - 1'b1) ? '0 : gnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ptr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_dat[i] <= '0;
        mem_sel[i] <= '0;
      end
    end else begin
      ptr <= nxt_ptr;
      if (push) begin
        mem_dat[wr_ptr] <= push_dat;
        mem_sel[wr_ptr] <= push_sel;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{sel_stb, sel_dat, ptr};

endmodule
